io_port_device: RTL and testbench

Board-side endpoint of the pipelined computer's memory-mapped I/O ports. It conditions raw slide switches and push buttons into the 32-bit `in_port0` word the CPU's MEM stage reads. It also displays the CPU-written `out_port0`/`out_port1` words on an 8-digit, time-multiplexed, active-low seven-segment display. It sits at the top level beside `pipelined_computer`, on the same `clock`.

---
 rtl/io_port_pkg.sv | 17 +
 rtl/io_debounce.sv | 56 +++++
 rtl/io_port_device.sv | 74 +++++++
 tb/tb_io_port_device.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants for the board I/O endpoint (digit count, in_port0 layout, hex-to-segment table)
package io_port_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam int SW_LSB = 0;
  localparam int KEY_LSB = 16;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // entry h is the active-low {dp,g,f,e,d,c,b,a} pattern for hex digit h
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  function automatic logic [7:0] hex_to_seg(input logic [3:0] h);
    return HEX_SEG[h];
  endfunction
endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchronizer plus per-bit debouncer (debounce stage only with IO_DEBOUNCE_EN)
// ports: clock, resetn (sync, active-low), raw_i (async bits), stable_o (conditioned bits)
module io_debounce
  import io_port_pkg::*;
#(
  parameter int W = 1,
  parameter int DB_CYCLES = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge clock)
    if (!resetn) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
`ifdef IO_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  logic [W-1:0] stable_q, stable_d;
  logic [W-1:0][CW-1:0] cnt_q, cnt_d;
  // a bit must disagree with its stable value for DB_CYCLES consecutive cycles to flip it
  always_comb begin
    stable_d = stable_q;
    cnt_d = cnt_q;
    for (int i = 0; i < W; i++) begin
      if (s2_q[i] == stable_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end
  always_ff @(posedge clock)
    if (!resetn) begin
      stable_q <= RST_VAL;
      cnt_q <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q <= cnt_d;
    end
  assign stable_o = stable_q;
`else
  // DB_CYCLES has no effect without the debounce stage
  if (DB_CYCLES < 2) begin : g_db_unused
  end
  assign stable_o = s2_q;
`endif
endmodule

// File: rtl/io_port_device.sv
// io_port_device: switch/key conditioning into in_port0 and 8-digit multiplexed hex display of out_port0/1
// ports: clock, resetn (sync, active-low), sw[9:0], key[3:0] (active-low), out_port0/1 (bits [15:0] shown),
//        in_port0 = {12'd0, ~key, 6'd0, sw}, an (active-low digit enable), seg (active-low {dp,g..a})
// IO_DEBOUNCE_EN: enables the debouncers; otherwise inputs are only synchronized
module io_port_device
  import io_port_pkg::*;
#(
  parameter int DB_CYCLES = 50000,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  output logic [31:0] in_port0,
  output logic [7:0]  an,
  output logic [7:0]  seg
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  logic [9:0] sw_db;
  logic [3:0] key_db;
  logic [31:0] in_port_q, in_port_d;
  logic [DW-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0] snap_q, snap_d;
  logic [7:0] an_q, seg_q;
  logic wrap;
  logic unused_hi;
  assign unused_hi = ^{out_port0[31:16], out_port1[31:16]};
  io_debounce #(.W(10), .DB_CYCLES(DB_CYCLES), .RST_VAL('0)) u_sw_db (
    .clock(clock),
    .resetn(resetn),
    .raw_i(sw),
    .stable_o(sw_db)
  );
  io_debounce #(.W(4), .DB_CYCLES(DB_CYCLES), .RST_VAL('1)) u_key_db (
    .clock(clock),
    .resetn(resetn),
    .raw_i(key),
    .stable_o(key_db)
  );
  // the snapshot only refreshes as the scan leaves the last digit, so a frame never mixes old and new writes
  always_comb begin
    in_port_d = '0;
    in_port_d[SW_LSB +: 10] = sw_db;
    in_port_d[KEY_LSB +: 4] = ~key_db;
    wrap = div_q == DIV_MAX;
    div_d = wrap ? '0 : div_q + 1'b1;
    idx_d = wrap ? idx_q + 1'b1 : idx_q;
    snap_d = (wrap && idx_q == IDX_LAST) ? {out_port1[15:0], out_port0[15:0]} : snap_q;
  end
  always_ff @(posedge clock)
    if (!resetn) begin
      in_port_q <= '0;
      div_q <= '0;
      idx_q <= '0;
      snap_q <= '0;
      an_q <= SEG_BLANK;
      seg_q <= SEG_BLANK;
    end else begin
      in_port_q <= in_port_d;
      div_q <= div_d;
      idx_q <= idx_d;
      snap_q <= snap_d;
      an_q <= ~(8'd1 << idx_q);
      seg_q <= hex_to_seg(snap_q[{idx_q, 2'b00} +: 4]);
    end
  assign in_port0 = in_port_q;
  assign an = an_q;
  assign seg = seg_q;
endmodule

// File: tb/tb_io_port_device.sv
// tb_io_port_device: directed checks of input conditioning and display scan for io_port_device
module tb_io_port_device;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [9:0] sw;
  logic [3:0] key;
  logic [31:0] out_port0, out_port1, in_port0;
  logic [7:0] an, seg;
  int n_cmp = 0;
  int n_bad = 0;
`ifdef IO_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  always #5 clock = ~clock;
  io_port_device #(.DB_CYCLES(4), .SCAN_DIV(3)) dut (
    .clock(clock),
    .resetn(resetn),
    .sw(sw),
    .key(key),
    .out_port0(out_port0),
    .out_port1(out_port1),
    .in_port0(in_port0),
    .an(an),
    .seg(seg)
  );
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  logic [7:0] f2 [8] = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hA1, 8'hC6, 8'h83, 8'h88};
  logic [7:0] f3 [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'hA1, 8'hC6, 8'h83, 8'h88};
  initial begin
    sw = 10'h3FF;
    key = 4'h0;
    out_port0 = '0;
    out_port1 = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rst_in%0d", k), in_port0, 32'h0);
      chk($sformatf("rst_an%0d", k), an, 32'hFF);
      chk($sformatf("rst_seg%0d", k), seg, 32'hFF);
    end
    sw = 10'h0;
    key = 4'hF;
    tick();
    resetn = 1'b1;
    tick(LAT + 1);
    chk("idle", in_port0, 32'h0);
    sw = 10'h155;
    tick(LAT - 1);
    chk("sw_early", in_port0, 32'h0);
    tick();
    chk("sw_on_time", in_port0, 32'h155);
    tick(5);
    chk("sw_held", in_port0, 32'h155);
    sw = 10'h0;
    tick(LAT);
    chk("sw_clear", in_port0, 32'h0);
`ifdef IO_DEBOUNCE_EN
    sw = 10'h1;
    tick(3);
    sw = 10'h0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("glitch3_%0d", k), in_port0, 32'h0);
    end
    sw = 10'h1;
    tick(4);
    sw = 10'h0;
    tick(2);
    chk("pulse4_early", in_port0, 32'h0);
    tick();
    chk("pulse4_set", in_port0, 32'h1);
    tick(3);
    chk("pulse4_hold", in_port0, 32'h1);
    tick();
    chk("pulse4_clear", in_port0, 32'h0);
`else
    sw = 10'h1;
    tick();
    sw = 10'h0;
    tick();
    chk("pulse1_early", in_port0, 32'h0);
    tick();
    chk("pulse1_set", in_port0, 32'h1);
    tick();
    chk("pulse1_clear", in_port0, 32'h0);
`endif
    key = 4'b1010;
    tick(LAT - 1);
    chk("key_early", in_port0, 32'h0);
    tick();
    chk("key_map", in_port0, 32'h0005_0000);
    sw = 10'h2AA;
    key = 4'h0;
    tick(LAT);
    chk("sw_key_all", in_port0, 32'h000F_02AA);
    sw = 10'h0;
    key = 4'hF;
    tick(LAT);
    chk("sw_key_off", in_port0, 32'h0);
    sw = 10'h3FF;
    tick(LAT - 2);
    resetn = 1'b0;
    tick(2);
    chk("midrst_in", in_port0, 32'h0);
    chk("midrst_an", an, 32'hFF);
    resetn = 1'b1;
    tick(LAT - 1);
    chk("postrst_early", in_port0, 32'h0);
    tick();
    chk("postrst_set", in_port0, 32'h3FF);
    sw = 10'h0;
    resetn = 1'b0;
    out_port0 = 32'hDEAD_1234;
    out_port1 = 32'hBEEF_ABCD;
    tick(2);
    chk("disp_rst_seg", seg, 32'hFF);
    resetn = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      int d, fr;
      logic [7:0] es;
      tick();
      d = ((k - 1) % 24) / 3;
      fr = (k - 1) / 24;
      es = fr == 0 ? 8'hC0 : fr == 1 ? f2[d] : f3[d];
      chk($sformatf("an_k%0d", k), an, {24'h0, ~(8'd1 << d)});
      chk($sformatf("seg_k%0d", k), seg, {24'h0, es});
      if (k == 30) out_port0 = 32'h0000_5678;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
